// File: rtl/choose_best_fixed_if.sv
// ============================================================================
// Module   : choose_best_fixed_if
// Brief    : Residual bundle from the fixed-encoder bank plus the chosen order.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface choose_best_fixed_if;
    logic               iEnable;
    logic signed [15:0] FE0_residual;
    logic signed [15:0] FE1_residual;
    logic signed [15:0] FE2_residual;
    logic signed [15:0] FE3_residual;
    logic signed [15:0] FE4_residual;
    logic        [2:0]  oBest;

    modport master (
        output iEnable,
        output FE0_residual,
        output FE1_residual,
        output FE2_residual,
        output FE3_residual,
        output FE4_residual,
        input  oBest
    );

    modport slave (
        input  iEnable,
        input  FE0_residual,
        input  FE1_residual,
        input  FE2_residual,
        input  FE3_residual,
        input  FE4_residual,
        output oBest
    );
endinterface

`default_nettype wire

// File: rtl/choose_best_fixed.sv
// ============================================================================
// Module   : choose_best_fixed
// Brief    : Per-block sum of |residual| for fixed orders 0..4; reports argmin.
// Revision : 1.0
// ============================================================================
`default_nettype none

module choose_best_fixed #(
    parameter int BLOCK_SIZE = 4096,
    parameter int ACC_W      = 32
) (
    input  wire logic          iClock,
    input  wire logic          iReset,
    choose_best_fixed_if.slave fe_bus
);

    localparam int             CNT_W  = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BLOCK_SIZE - 1);
    localparam int             NUM_ORD = 5;

    logic [15:0]      w_res  [NUM_ORD];
    logic [ACC_W-1:0] w_abs  [NUM_ORD];
    logic [ACC_W-1:0] w_sum  [NUM_ORD];

    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc  [NUM_ORD];
    logic [ACC_W-1:0] r_snap [NUM_ORD];
    logic             r_pending;
    logic [2:0]       r_best;

    logic [2:0]       w_min_idx;
    logic [ACC_W-1:0] w_min_val;

    assign w_res[0] = fe_bus.FE0_residual;
    assign w_res[1] = fe_bus.FE1_residual;
    assign w_res[2] = fe_bus.FE2_residual;
    assign w_res[3] = fe_bus.FE3_residual;
    assign w_res[4] = fe_bus.FE4_residual;

    // 17-bit magnitude so that |-32768| is exact rather than saturated.
    generate
        for (genvar k = 0; k < NUM_ORD; k++) begin : g_abs
            logic [16:0] w_ext;
            logic [16:0] w_mag;
            assign w_ext    = {w_res[k][15], w_res[k]};
            assign w_mag    = w_ext[16] ? (~w_ext + 17'd1) : w_ext;
            assign w_abs[k] = {{(ACC_W-17){1'b0}}, w_mag};
            assign w_sum[k] = r_acc[k] + w_abs[k];
        end
    endgenerate

    // Strict less-than scanned upward: ties resolve to the lowest order.
    always_comb begin
        w_min_idx = 3'd0;
        w_min_val = r_snap[0];
        for (int k = 1; k < NUM_ORD; k++) begin
            if (r_snap[k] < w_min_val) begin
                w_min_val = r_snap[k];
                w_min_idx = 3'(k);
            end
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
            r_best    <= 3'd0;
            for (int k = 0; k < NUM_ORD; k++) begin
                r_acc[k]  <= '0;
                r_snap[k] <= '0;
            end
        end else begin
            // The compare of block n overlaps the first sample of block n+1.
            if (r_pending) begin
                r_best    <= w_min_idx;
                r_pending <= 1'b0;
            end
            if (fe_bus.iEnable) begin
                if (r_cnt == C_LAST) begin
                    for (int k = 0; k < NUM_ORD; k++) begin
                        r_snap[k] <= w_sum[k];
                        r_acc[k]  <= '0;
                    end
                    r_cnt     <= '0;
                    r_pending <= 1'b1;
                end else begin
                    for (int k = 0; k < NUM_ORD; k++) begin
                        r_acc[k] <= w_sum[k];
                    end
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign fe_bus.oBest = r_best;

endmodule

`default_nettype wire

// File: tb/tb_choose_best_fixed.sv
// ============================================================================
// Module   : tb_choose_best_fixed
// Brief    : Directed self-checking bench for choose_best_fixed.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_choose_best_fixed;

    localparam int BLK = 4096;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    choose_best_fixed_if bus ();

    choose_best_fixed #(
        .BLOCK_SIZE (BLK),
        .ACC_W      (32)
    ) dut (
        .iClock (clk),
        .iReset (rst),
        .fe_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic signed [15:0] a, input logic signed [15:0] b,
                         input logic signed [15:0] c, input logic signed [15:0] d,
                         input logic signed [15:0] e, input logic en);
        bus.FE0_residual = a;
        bus.FE1_residual = b;
        bus.FE2_residual = c;
        bus.FE3_residual = d;
        bus.FE4_residual = e;
        bus.iEnable      = en;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            step();
        end
        rst = 1'b0;
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        checks++;
        if (bus.oBest !== 3'd0) begin
            errors++;
            $display("FAIL reset_value: got %0d expected 0", bus.oBest);
        end
    endtask

    task automatic test_clear_winner();
        for (int i = 0; i < BLK; i++) begin
            drive(16'sd100, 16'sd100, 16'sd0, 16'sd100, 16'sd100, 1'b1);
            step();
            if (i == 2047) begin
                checks++;
                if (bus.oBest !== 3'd0) begin
                    errors++;
                    $display("FAIL clear_midblock: got %0d expected 0", bus.oBest);
                end
            end
        end
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        checks++;
        if (bus.oBest !== 3'd0) begin
            errors++;
            $display("FAIL clear_not_early: got %0d expected 0", bus.oBest);
        end
        step();
        checks++;
        if (bus.oBest !== 3'd2) begin
            errors++;
            $display("FAIL clear_winner: got %0d expected 2", bus.oBest);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (bus.oBest !== 3'd2) begin
            errors++;
            $display("FAIL clear_hold: got %0d expected 2", bus.oBest);
        end
    endtask

    task automatic test_ties_extremes();
        for (int i = 0; i < BLK; i++) begin
            drive(16'sd7, 16'sd7, 16'sd7, 16'sd7, 16'sd7, 1'b1);
            step();
        end
        // First sample of block 2 lands on the compare edge of block 1.
        drive(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 16'sd32767, 1'b1);
        step();
        checks++;
        if (bus.oBest !== 3'd0) begin
            errors++;
            $display("FAIL tie_lowest: got %0d expected 0", bus.oBest);
        end
        for (int i = 1; i < BLK; i++) step();
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        step();
        checks++;
        if (bus.oBest !== 3'd4) begin
            errors++;
            $display("FAIL extremes: got %0d expected 4", bus.oBest);
        end
    endtask

    task automatic test_sign();
        for (int i = 0; i < BLK; i++) begin
            drive(-16'sd1, 16'sd2, -16'sd5, -16'sd5, -16'sd5, 1'b1);
            step();
        end
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        step();
        checks++;
        if (bus.oBest !== 3'd0) begin
            errors++;
            $display("FAIL sign: got %0d expected 0", bus.oBest);
        end
    endtask

    task automatic test_enable_gap();
        for (int i = 0; i < 2000; i++) begin
            drive(16'sd50, 16'sd40, 16'sd30, 16'sd10, 16'sd20, 1'b1);
            step();
        end
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        for (int i = 0; i < 10; i++) step();
        checks++;
        if (bus.oBest !== 3'd0) begin
            errors++;
            $display("FAIL gap_hold: got %0d expected 0", bus.oBest);
        end
        for (int i = 2000; i < BLK; i++) begin
            drive(16'sd50, 16'sd40, 16'sd30, 16'sd10, 16'sd20, 1'b1);
            step();
            if (i == BLK - 11) begin
                checks++;
                if (bus.oBest !== 3'd0) begin
                    errors++;
                    $display("FAIL gap_not_early: got %0d expected 0", bus.oBest);
                end
            end
        end
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        checks++;
        if (bus.oBest !== 3'd0) begin
            errors++;
            $display("FAIL gap_last_edge: got %0d expected 0", bus.oBest);
        end
        step();
        checks++;
        if (bus.oBest !== 3'd3) begin
            errors++;
            $display("FAIL gap_winner: got %0d expected 3", bus.oBest);
        end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3000; i++) begin
            drive(16'sd1000, 16'sd0, 16'sd1000, 16'sd1000, 16'sd1000, 1'b1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (bus.oBest !== 3'd0) begin
            errors++;
            $display("FAIL midreset_clear: got %0d expected 0", bus.oBest);
        end
        for (int i = 0; i < BLK; i++) begin
            drive(16'sd5, 16'sd5, 16'sd5, 16'sd5, 16'sd4, 1'b1);
            step();
            if (i == 2000) begin
                checks++;
                if (bus.oBest !== 3'd0) begin
                    errors++;
                    $display("FAIL midreset_not_early: got %0d expected 0", bus.oBest);
                end
            end
        end
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        step();
        checks++;
        if (bus.oBest !== 3'd4) begin
            errors++;
            $display("FAIL midreset_winner: got %0d expected 4", bus.oBest);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 1'b0);
        test_reset();
        test_clear_winner();
        test_ties_extremes();
        test_sign();
        test_enable_gap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/choose_best_fixed.md
# choose_best_fixed

Selects the best FLAC fixed-predictor order for each block of audio. Every enabled cycle it takes the five residuals produced by the order-0..4 fixed encoders for the same sample and accumulates their absolute values. At the end of each block it reports the order with the smallest total. It sits between the fixed-encoder bank and the subframe/Rice encoding stage.

## Interface
- BLOCK_SIZE, 4096: samples per block (enabled cycles).
- ACC_W, 32: accumulator width; must satisfy ACC_W ≥ 17 + log2(BLOCK_SIZE).

Ports:
- iClock  in  1  sole clock; all state updates on rising edge.
- iReset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- iEnable  in  1  a valid, aligned residual set is present this cycle.
- FE0_residual  in  16  signed residual, order-0 predictor.
- FE1_residual  in  16  signed residual, order-1 predictor.
- FE2_residual  in  16  signed residual, order-2 predictor.
- FE3_residual  in  16  signed residual, order-3 predictor.
- FE4_residual  in  16  signed residual, order-4 predictor.
- oBest  out  3  registered index 0..4 of the winning order for the last completed block.

## Operation
- The upstream encoders deliver all five residuals sample-aligned. Every enabled cycle is counted, including warm-up samples; no samples are skipped.
- Absolute value: |r| is computed as a 17-bit unsigned value, so |-32768| = 32768 with no saturation. The result is zero-extended to ACC_W.
- State:
  - sample counter 0..BLOCK_SIZE-1;
  - five accumulators acc0..acc4;
  - five snapshot registers snap0..snap4;
  - 1-bit compare-pending flag;
  - oBest.
- Enabled cycle, counter < BLOCK_SIZE-1: acc_k += |FEk_residual| for each k; counter increments.
- Enabled cycle, counter == BLOCK_SIZE-1 (last sample):
  - snap_k ← acc_k + |FEk_residual|;
  - acc_k ← 0;
  - counter ← 0;
  - pending ← 1.
  - The next block therefore starts on the following enabled cycle with no gap.
- Compare cycle (pending == 1): oBest ← index of the minimum snap_k; pending ← 0. This step runs regardless of iEnable.
- Tie-break: the lowest order index wins. Comparisons are strict less-than, scanned 0→4.
- iEnable low: accumulators and counter hold; a pending compare still completes.
- oBest holds its value between block ends.

## Timing
- Reset (iReset high at an edge): counter, acc_k, snap_k and pending are cleared; oBest = 0. Reset overrides iEnable.
- Reset mid-block discards the partial block; counting restarts at 0 on the first enabled cycle after reset.
- Latency: oBest updates on the edge following the edge that accepts the last sample of a block. It is visible one cycle after the final sample.
- Back-to-back blocks: the compare for block n overlaps the first sample of block n+1 without interference.
- No arithmetic overflow: the worst case is 4096 × 32768 = 2^27, which fits in ACC_W = 32.
- Output is purely registered; no combinational path from inputs to oBest.

## Test plan
- Reset: hold iReset 2 cycles with random residuals and iEnable=1 → oBest = 0, and it stays 0 until the first block completes.
- Clear winner: FE2 = 0 and FE0/1/3/4 = 100 for 4096 enabled cycles → oBest = 2 exactly one cycle after the 4096th sample, and not earlier.
- Sign handling: FE0 = -1, FE1 = +2, FE2..FE4 = -5 for one block → oBest = 0.
- Ties and extremes, two blocks:
  - block 1: all residuals equal (e.g. 7) → oBest = 0;
  - block 2: FE0..FE3 = -32768, FE4 = 32767 → oBest = 4, no overflow.
- Enable gaps: deassert iEnable for 10 cycles at sample 2000 with FE3 lowest → oBest = 3 only after 4096 enabled samples (4106 + 1 cycles from start).
- Mid-block reset: run 3000 samples with FE1 best, pulse iReset, then run a full block with FE4 best → oBest = 4, with no contribution from the pre-reset samples.
